// File: rtl/clkdiv_pkg.sv
// Shared types, defaults and the millivolt conversion for the programmable clock divider.
package clkdiv_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int DIV_W_DEF = 8;
   localparam int N_OUT_DEF = 3;
   localparam int TRIG_DEF  = 48;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Samples carry millivolts with two fractional bits.
   function automatic sample_t from_mv(input sample_t mv);
      return mv <<< 2;
   endfunction

   localparam sample_t SCHMITT_HI_DEF = from_mv(16'sd2000);
   localparam sample_t SCHMITT_LO_DEF = from_mv(16'sd500);
   localparam sample_t OUT_HI_DEF     = from_mv(16'sd5000);
   localparam sample_t OUT_LO_DEF     = from_mv(16'sd0);

endpackage

// File: rtl/schmitt_edge.sv
// Strobe-qualified Schmitt trigger on a signed CV sample with a rise pulse.
// state_nxt exposes the level the flop takes at the end of the current cycle.
module schmitt_edge
   import clkdiv_pkg::*;
#(
   parameter int W = SAMPLE_W
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         strobe,
   input  logic [W-1:0] sample,
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   output logic         state,
   output logic         state_nxt,
   output logic         rise
);

   logic state_r;
   logic state_nxt_s;
   logic above_s;
   logic below_s;

   // Hysteresis next-state; values between the thresholds hold.
   always_comb begin
      above_s = $signed(sample) > $signed(hi);
      below_s = $signed(sample) < $signed(lo);
      if (!strobe) begin
         state_nxt_s = state_r;
      end else if (!state_r && above_s) begin
         state_nxt_s = 1'b1;
      end else if (state_r && below_s) begin
         state_nxt_s = 1'b0;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Schmitt state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   assign rise      = strobe & ~state_r & above_s;
   assign state     = state_r;
   assign state_nxt = state_nxt_s;

endmodule

// File: rtl/clkdiv_prog.sv
// N_OUT-channel programmable clock divider with square/gate or trigger outputs.
// Define CLKDIV_RESET_IN_EN to enable the reset CV input.
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int W            = SAMPLE_W,
   parameter int N_OUT        = N_OUT_DEF,
   parameter int DIV_W        = DIV_W_DEF,
   parameter int SCHMITT_HI   = int'(SCHMITT_HI_DEF),
   parameter int SCHMITT_LO   = int'(SCHMITT_LO_DEF),
   parameter int OUT_HI       = int'(OUT_HI_DEF),
   parameter int OUT_LO       = int'(OUT_LO_DEF),
   parameter int TRIG_SAMPLES = TRIG_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_strobe,
   input  logic [W-1:0]           sample_clk_in,
   input  logic [W-1:0]           sample_rst_in,
   input  logic [N_OUT*DIV_W-1:0] div_ratio,
   input  logic [N_OUT-1:0]       trig_mode,
   output logic [N_OUT*W-1:0]     sample_out,
   output logic                   clk_state
);

   localparam int             TCNT_W   = $clog2(TRIG_SAMPLES + 1);
   localparam logic [W-1:0]   HI_TH    = W'(SCHMITT_HI);
   localparam logic [W-1:0]   LO_TH    = W'(SCHMITT_LO);
   localparam logic [W-1:0]   OUT_HI_V = W'(OUT_HI);
   localparam logic [W-1:0]   OUT_LO_V = W'(OUT_LO);
   localparam logic [DIV_W-1:0] ARMED  = {DIV_W{1'b1}};
   localparam logic [DIV_W-1:0] ONE_R  = {{(DIV_W-1){1'b0}}, 1'b1};

   logic                clk_state_s;
   logic                clk_state_nxt_s;
   logic                clk_rise_s;
   logic                rst_rise_s;
   logic [DIV_W-1:0]    cnt_r        [N_OUT];
   logic [DIV_W-1:0]    cnt_nxt_s    [N_OUT];
   logic [DIV_W-1:0]    cnt_base_s   [N_OUT];
   logic [DIV_W-1:0]    r_eff_s      [N_OUT];
   logic [DIV_W-1:0]    thresh_s     [N_OUT];
   logic [DIV_W:0]      inc_s        [N_OUT];
   logic [TCNT_W-1:0]   tcnt_r       [N_OUT];
   logic [TCNT_W-1:0]   tcnt_nxt_s   [N_OUT];
   logic [TCNT_W-1:0]   tcnt_base_s  [N_OUT];
   logic [N_OUT-1:0]    downbeat_s;
   logic [N_OUT-1:0]    high_s;
   logic [N_OUT*W-1:0]  out_nxt_s;
   logic [N_OUT*W-1:0]  sample_out_r;

   schmitt_edge #(.W(W)) u_clk_schmitt (
      .clk       (clk),
      .rst       (rst),
      .strobe    (sample_strobe),
      .sample    (sample_clk_in),
      .hi        (HI_TH),
      .lo        (LO_TH),
      .state     (clk_state_s),
      .state_nxt (clk_state_nxt_s),
      .rise      (clk_rise_s)
   );

`ifdef CLKDIV_RESET_IN_EN
   logic rst_state_unused_s;
   logic rst_state_nxt_unused_s;

   schmitt_edge #(.W(W)) u_rst_schmitt (
      .clk       (clk),
      .rst       (rst),
      .strobe    (sample_strobe),
      .sample    (sample_rst_in),
      .hi        (HI_TH),
      .lo        (LO_TH),
      .state     (rst_state_unused_s),
      .state_nxt (rst_state_nxt_unused_s),
      .rise      (rst_rise_s)
   );
`else
   logic rst_in_unused_s;

   assign rst_rise_s      = 1'b0;
   assign rst_in_unused_s = ^sample_rst_in;
`endif

   // Per-channel counter, trigger and output shaping; a reset rise re-arms before the clock rise counts.
   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
         r_eff_s[k] = (div_ratio[k*DIV_W +: DIV_W] == {DIV_W{1'b0}}) ? ONE_R
                                                                     : div_ratio[k*DIV_W +: DIV_W];
         if (rst_rise_s) begin
            cnt_base_s[k]  = ARMED;
            tcnt_base_s[k] = {TCNT_W{1'b0}};
         end else begin
            cnt_base_s[k]  = cnt_r[k];
            tcnt_base_s[k] = tcnt_r[k];
         end
         inc_s[k]      = {1'b0, cnt_base_s[k]} + {{DIV_W{1'b0}}, 1'b1};
         downbeat_s[k] = 1'b0;
         if (clk_rise_s) begin
            if (inc_s[k] >= {1'b0, r_eff_s[k]}) begin
               cnt_nxt_s[k]  = {DIV_W{1'b0}};
               downbeat_s[k] = 1'b1;
            end else begin
               cnt_nxt_s[k]  = inc_s[k][DIV_W-1:0];
            end
         end else begin
            cnt_nxt_s[k] = cnt_base_s[k];
         end
         if (downbeat_s[k]) begin
            tcnt_nxt_s[k] = TCNT_W'(TRIG_SAMPLES);
         end else if (tcnt_base_s[k] != {TCNT_W{1'b0}}) begin
            tcnt_nxt_s[k] = tcnt_base_s[k] - {{(TCNT_W-1){1'b0}}, 1'b1};
         end else begin
            tcnt_nxt_s[k] = tcnt_base_s[k];
         end
         thresh_s[k] = r_eff_s[k] - (r_eff_s[k] >> 1);
         if (trig_mode[k]) begin
            high_s[k] = (tcnt_nxt_s[k] != {TCNT_W{1'b0}});
         end else if (r_eff_s[k] == ONE_R) begin
            high_s[k] = clk_state_nxt_s;
         end else begin
            high_s[k] = (cnt_nxt_s[k] != ARMED) && (cnt_nxt_s[k] < thresh_s[k]);
         end
         out_nxt_s[k*W +: W] = high_s[k] ? OUT_HI_V : OUT_LO_V;
      end
   end

   // Channel state and output registers advance only on strobe cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_OUT; k++) begin
            cnt_r[k]  <= ARMED;
            tcnt_r[k] <= {TCNT_W{1'b0}};
         end
         sample_out_r <= {N_OUT{OUT_LO_V}};
      end else if (sample_strobe) begin
         for (int k = 0; k < N_OUT; k++) begin
            cnt_r[k]  <= cnt_nxt_s[k];
            tcnt_r[k] <= tcnt_nxt_s[k];
         end
         sample_out_r <= out_nxt_s;
      end
   end

   assign sample_out = sample_out_r;
   assign clk_state  = clk_state_s;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: directed test-plan steps plus random stimulus against a reference model.
module tb_clkdiv_prog;

   localparam int W    = 16;
   localparam int N    = 3;
   localparam int DW   = 8;
   localparam int TRIG = 48;
   localparam logic [W-1:0] HI = 16'd20000;
   localparam logic [W-1:0] LO = 16'd0;

   logic            clk = 1'b0;
   logic            rst;
   logic            sample_strobe;
   logic [W-1:0]    sample_clk_in;
   logic [W-1:0]    sample_rst_in;
   logic [N*DW-1:0] div_ratio;
   logic [N-1:0]    trig_mode;
   logic [N*W-1:0]  sample_out;
   logic            clk_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase within the divide cycle and strobe index of the last downbeat.
   bit m_clk, m_rst;
   bit armed [N];
   int pos [N];
   int last_db [N];
   int ratio [N];
   bit mode [N];
   int sidx;

   always #5 clk = ~clk;

   clkdiv_prog dut (
      .clk           (clk),
      .rst           (rst),
      .sample_strobe (sample_strobe),
      .sample_clk_in (sample_clk_in),
      .sample_rst_in (sample_rst_in),
      .div_ratio     (div_ratio),
      .trig_mode     (trig_mode),
      .sample_out    (sample_out),
      .clk_state     (clk_state)
   );

   function automatic logic [W-1:0] mv2s(input int mv);
      return W'(mv * 4);
   endfunction

   function automatic logic [W-1:0] lv(input bit h);
      return h ? HI : LO;
   endfunction

   function automatic void model_reset();
      m_clk = 1'b0;
      m_rst = 1'b0;
      sidx  = 0;
      for (int k = 0; k < N; k++) begin
         armed[k]   = 1'b1;
         pos[k]     = 0;
         last_db[k] = -1000;
      end
   endfunction

   function automatic void model_step(input int cmv, input int rmv);
      bit rc, rr;
      int r;
      sidx++;
      rc = !m_clk && (cmv > 2000);
      if (cmv > 2000) m_clk = 1'b1;
      else if (cmv < 500) m_clk = 1'b0;
      rr = 1'b0;
`ifdef CLKDIV_RESET_IN_EN
      rr = !m_rst && (rmv > 2000);
      if (rmv > 2000) m_rst = 1'b1;
      else if (rmv < 500) m_rst = 1'b0;
`endif
      if (rr) begin
         for (int k = 0; k < N; k++) begin
            armed[k]   = 1'b1;
            last_db[k] = -1000;
         end
      end
      if (rc) begin
         for (int k = 0; k < N; k++) begin
            r = (ratio[k] == 0) ? 1 : ratio[k];
            if (armed[k]) begin
               armed[k] = 1'b0;
               pos[k]   = 0;
            end else begin
               pos[k] = pos[k] + 1;
               if (pos[k] >= r) pos[k] = 0;
            end
            if (pos[k] == 0) last_db[k] = sidx;
         end
      end
   endfunction

   function automatic logic [N*W-1:0] exp_out();
      logic [N*W-1:0] e;
      bit h;
      int r;
      for (int k = 0; k < N; k++) begin
         r = (ratio[k] == 0) ? 1 : ratio[k];
         if (mode[k]) h = (sidx - last_db[k]) < TRIG;
         else if (r == 1) h = m_clk;
         else if (armed[k]) h = 1'b0;
         else h = pos[k] < (r + 1) / 2;
         e[k*W +: W] = lv(h);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int r0, input int r1, input int r2, input logic [2:0] m);
      ratio[0] = r0; ratio[1] = r1; ratio[2] = r2;
      for (int k = 0; k < N; k++) mode[k] = m[k];
      div_ratio = {DW'(r2), DW'(r1), DW'(r0)};
      trig_mode = m;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_out", sample_out, {N{LO}});
      chk("rst_clk_state", clk_state, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic do_strobe(input int cmv, input int rmv, input int gap);
      @(negedge clk);
      sample_clk_in = mv2s(cmv);
      sample_rst_in = mv2s(rmv);
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      sample_clk_in = W'($urandom);
      sample_rst_in = W'($urandom);
      model_step(cmv, rmv);
      chk("out", sample_out, exp_out());
      chk("clk_state", clk_state, m_clk);
      if (gap > 0) begin
         repeat (gap) @(negedge clk);
         chk("hold", sample_out, exp_out());
      end
   endtask

   initial begin
      int cvt [7] = '{0, 400, 1000, 1500, 2100, 5000, -2000};
      int hv [6]  = '{0, 1500, 2100, 1000, 400, 2100};
      bit hs [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int hi_cnt, trans;
      bit prev, all_hi;

      rst = 1'b0;
      sample_strobe = 1'b0;
      sample_clk_in = '0;
      sample_rst_in = '0;
      set_cfg(2, 4, 8, 3'b000);
      model_reset();
      do_reset();

      // Square division by 2/4/8 checked against the expected rise patterns.
      for (int n = 1; n <= 16; n++) begin
         do_strobe(5000, 0, 0);
         chk("sq_div", sample_out, {lv(((n - 1) % 8) < 4), lv(((n - 1) % 4) < 2), lv((n % 2) == 1)});
         do_strobe(0, 0, 0);
      end

      // Hysteresis: two rise events, fixed state sequence.
      prev  = clk_state;
      trans = 0;
      for (int i = 0; i < 6; i++) begin
         do_strobe(hv[i], 0, 0);
         chk("hyst_state", clk_state, hs[i]);
         if (clk_state && !prev) trans++;
         prev = clk_state;
      end
      chk("hyst_rises", trans, 2);
      do_strobe(0, 0, 0);

      // Trigger mode, r = 3, rises 20 strobes apart: 3 downbeats x 48 strobes high.
      set_cfg(3, 3, 3, 3'b111);
      do_reset();
      hi_cnt = 0;
      for (int s = 0; s < 180; s++) begin
         do_strobe((s % 20 == 0) ? 5000 : 0, 0, 0);
         if (sample_out[W-1:0] == HI) hi_cnt++;
      end
      chk("trig_len", hi_cnt, 144);

      // Retrigger with r = 1 keeps the output continuously high.
      set_cfg(1, 1, 1, 3'b111);
      all_hi = 1'b1;
      for (int s = 0; s < 100; s++) begin
         do_strobe((s % 20 == 0) ? 5000 : 0, 0, 0);
         if (sample_out !== {N{HI}}) all_hi = 1'b0;
      end
      chk("retrig_hi", all_hi, 1'b1);

      // Reset CV behaviour.
      set_cfg(4, 4, 4, 3'b000);
      do_reset();
      for (int n = 0; n < 5; n++) begin
         do_strobe(5000, 0, 0);
         do_strobe(0, 0, 0);
      end
      do_strobe(0, 5000, 0);
`ifdef CLKDIV_RESET_IN_EN
      chk("rstin_lo", sample_out, {N{LO}});
`endif
      do_strobe(0, 0, 0);
      do_strobe(5000, 0, 0);
      chk("rstin_downbeat", sample_out, {N{HI}});
      for (int n = 0; n < 2; n++) begin
         do_strobe(0, 0, 0);
         do_strobe(5000, 0, 0);
      end
      do_strobe(0, 0, 0);
      do_strobe(5000, 5000, 0);
`ifdef CLKDIV_RESET_IN_EN
      chk("rstin_simul", sample_out, {N{HI}});
`endif
      do_strobe(0, 0, 0);

      // Lowering r from 8 to 3 with the count at 6 forces a wrap.
      set_cfg(8, 8, 8, 3'b000);
      do_reset();
      for (int n = 0; n < 7; n++) begin
         do_strobe(5000, 0, 0);
         do_strobe(0, 0, 0);
      end
      chk("r8_pos6_low", sample_out, {N{LO}});
      set_cfg(3, 3, 3, 3'b000);
      do_strobe(5000, 0, 0);
      chk("ratio_wrap", sample_out, {N{HI}});
      do_strobe(0, 0, 0);

      // r = 0 is a gate passthrough.
      set_cfg(0, 0, 0, 3'b000);
      for (int i = 0; i < 8; i++) begin
         do_strobe(cvt[$urandom_range(0, 6)], 0, 0);
         chk("r0_gate", sample_out, {N{lv(m_clk)}});
      end

      // Strobes gapped by 250 clocks; outputs must hold between them.
      set_cfg(2, 3, 1, 3'b010);
      for (int i = 0; i < 6; i++) do_strobe((i % 2 == 0) ? 5000 : 0, 0, 250);

      // Random configurations, CVs and strobe gaps.
      for (int i = 0; i < 400; i++) begin
         if (i % 16 == 0)
            set_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), 3'($urandom));
         do_strobe(cvt[$urandom_range(0, 6)], ($urandom_range(0, 15) == 0) ? 5000 : 0,
                   int'($urandom_range(0, 3)));
      end

      // Async reset while outputs are high, away from any clock edge.
      set_cfg(1, 1, 1, 3'b000);
      do_strobe(5000, 0, 0);
      chk("pre_rst_hi", sample_out, {N{HI}});
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
